// File: rtl/ifu_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch_queue
// Brief    : PC generation, single-outstanding I-Cache fetch and bundle queue.
// Revision : 1.0
// ============================================================================
module ifu_fetch_queue #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INST_WIDTH  = 32,
  parameter int                    FETCH_WIDTH = 2,
  parameter int                    QUEUE_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR   = '0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              bpu_taken_i,
  input  logic [ADDR_WIDTH-1:0]             bpu_addr_i,
  input  logic                              bru_miss_i,
  input  logic [ADDR_WIDTH-1:0]             bru_addr_i,
  input  logic                              exception_flush_i,
  input  logic [ADDR_WIDTH-1:0]             exception_addr_i,
  input  logic                              stall_i,
  output logic                              icache_req_valid_o,
  input  logic                              icache_req_ready_i,
  output logic [ADDR_WIDTH-1:0]             icache_addr_o,
  input  logic                              icache_resp_valid_i,
  input  logic [FETCH_WIDTH*INST_WIDTH-1:0] icache_resp_data_i,
  output logic                              deq_valid_o,
  input  logic                              deq_ready_i,
  output logic [FETCH_WIDTH*INST_WIDTH-1:0] deq_inst_o,
  output logic [FETCH_WIDTH-1:0]            deq_mask_o,
  output logic [ADDR_WIDTH-1:0]             deq_pc_o,
  output logic                              deq_misaligned_o,
  output logic                              ifu_flush_o,
  output logic [$clog2(QUEUE_DEPTH):0]      queue_count_o
);

  localparam int c_BW_BYTES = FETCH_WIDTH * 4;
  localparam int c_OFF_BITS = $clog2(c_BW_BYTES);
  localparam int c_PTR_W    = $clog2(QUEUE_DEPTH);
  localparam int c_CNT_W    = c_PTR_W + 1;
  localparam int c_DATA_W   = FETCH_WIDTH * INST_WIDTH;
  localparam logic [c_CNT_W-1:0]    c_DEPTH  = c_CNT_W'(QUEUE_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] c_BW_INC = ADDR_WIDTH'(c_BW_BYTES);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;
  localparam logic [1:0] S_EXC  = 2'd3;

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [c_PTR_W-1:0]    r_head;
  logic [c_PTR_W-1:0]    r_tail;
  logic [c_CNT_W-1:0]    r_count;
  logic                  r_marker_done;
  logic                  r_orphan;

  logic [c_DATA_W-1:0]    r_q_inst [QUEUE_DEPTH];
  logic [FETCH_WIDTH-1:0] r_q_mask [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0]  r_q_pc   [QUEUE_DEPTH];
  logic                   r_q_mis  [QUEUE_DEPTH];

  logic                   w_flush;
  logic [ADDR_WIDTH-1:0]  w_flush_tgt;
  logic                   w_req_valid;
  logic                   w_req_fire;
  logic                   w_resp_take;
  logic                   w_marker;
  logic                   w_enq;
  logic                   w_deq;
  logic                   w_outstanding;
  logic [ADDR_WIDTH-1:0]  w_aligned;
  logic [ADDR_WIDTH-1:0]  w_next_pc;
  logic [FETCH_WIDTH-1:0] w_mask;

  assign w_aligned = {r_pc[ADDR_WIDTH-1:c_OFF_BITS], {c_OFF_BITS{1'b0}}};
  assign w_next_pc = bpu_taken_i ? bpu_addr_i : (w_aligned + c_BW_INC);

  // Slots below the PC's offset within the line are not part of this bundle
  generate
    if (FETCH_WIDTH > 1) begin : g_multi
      localparam int c_SLOT_W = c_OFF_BITS - 2;
      logic [c_SLOT_W-1:0] w_slot;
      assign w_slot = r_pc[c_OFF_BITS-1:2];
      for (genvar gi = 0; gi < FETCH_WIDTH; gi++) begin : g_slot
        assign w_mask[gi] = (w_slot <= c_SLOT_W'(gi));
      end
    end else begin : g_single
      assign w_mask = 1'b1;
    end
  endgenerate

  always_comb begin
    w_flush     = exception_flush_i || bru_miss_i;
    w_flush_tgt = exception_flush_i ? exception_addr_i : bru_addr_i;
    w_req_valid = (r_state == S_REQ) && !stall_i && (r_count < c_DEPTH);
    w_req_fire  = w_req_valid && icache_req_ready_i;
    w_resp_take = (r_state == S_WAIT) && icache_resp_valid_i && !w_flush;
    w_marker    = (r_state == S_EXC) && !r_marker_done && (r_count < c_DEPTH) && !w_flush;
    w_enq       = w_resp_take || w_marker;
    w_deq       = (r_count != '0) && deq_ready_i && !w_flush;
    // A request still in flight after a flush must have its response discarded
    case (r_state)
      S_REQ:   w_outstanding = w_req_fire;
      S_EXC:   w_outstanding = r_orphan && !icache_resp_valid_i;
      default: w_outstanding = !icache_resp_valid_i;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_REQ;
      r_pc          <= BOOT_ADDR;
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_marker_done <= 1'b0;
      r_orphan      <= 1'b0;
    end else if (w_flush) begin
      r_pc          <= w_flush_tgt;
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_marker_done <= 1'b0;
      if (w_flush_tgt[1:0] != 2'b00) begin
        r_state  <= S_EXC;
        r_orphan <= w_outstanding;
      end else begin
        r_state  <= w_outstanding ? S_DROP : S_REQ;
        r_orphan <= 1'b0;
      end
    end else begin
      if (w_enq) r_tail <= r_tail + c_PTR_W'(1);
      if (w_deq) r_head <= r_head + c_PTR_W'(1);
      if (w_enq && !w_deq)      r_count <= r_count + c_CNT_W'(1);
      else if (!w_enq && w_deq) r_count <= r_count - c_CNT_W'(1);
      case (r_state)
        S_REQ: if (w_req_fire) r_state <= S_WAIT;
        S_WAIT: begin
          if (icache_resp_valid_i) begin
            r_pc          <= w_next_pc;
            r_marker_done <= 1'b0;
            r_state       <= (bpu_taken_i && (bpu_addr_i[1:0] != 2'b00)) ? S_EXC : S_REQ;
          end
        end
        S_DROP: if (icache_resp_valid_i) r_state <= S_REQ;
        S_EXC: begin
          if (w_marker) r_marker_done <= 1'b1;
          if (icache_resp_valid_i) r_orphan <= 1'b0;
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

  // Queue storage needs no reset: outputs are gated by occupancy
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_q_inst[r_tail] <= w_resp_take ? icache_resp_data_i : '0;
      r_q_mask[r_tail] <= w_resp_take ? w_mask : '0;
      r_q_pc[r_tail]   <= r_pc;
      r_q_mis[r_tail]  <= !w_resp_take;
    end
  end

  assign icache_req_valid_o = w_req_valid;
  assign icache_addr_o      = w_aligned;
  assign ifu_flush_o        = w_flush;
  assign queue_count_o      = r_count;
  assign deq_valid_o        = (r_count != '0);
  assign deq_inst_o         = deq_valid_o ? r_q_inst[r_head] : '0;
  assign deq_mask_o         = deq_valid_o ? r_q_mask[r_head] : '0;
  assign deq_pc_o           = deq_valid_o ? r_q_pc[r_head] : '0;
  assign deq_misaligned_o   = deq_valid_o ? r_q_mis[r_head] : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch_queue.sv
`default_nettype none
// Bench for ifu_fetch_queue: directed scenarios plus a randomized run against
// a queue-based reference model of the fetch unit.
module tb_ifu_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        bpu_taken_i;
  logic [31:0] bpu_addr_i;
  logic        bru_miss_i;
  logic [31:0] bru_addr_i;
  logic        exception_flush_i;
  logic [31:0] exception_addr_i;
  logic        stall_i;
  logic        icache_req_valid_o;
  logic        icache_req_ready_i;
  logic [31:0] icache_addr_o;
  logic        icache_resp_valid_i;
  logic [63:0] icache_resp_data_i;
  logic        deq_valid_o;
  logic        deq_ready_i;
  logic [63:0] deq_inst_o;
  logic [1:0]  deq_mask_o;
  logic [31:0] deq_pc_o;
  logic        deq_misaligned_o;
  logic        ifu_flush_o;
  logic [2:0]  queue_count_o;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [63:0] inst;
    logic [1:0]  mask;
    logic [31:0] pc;
    logic        mis;
  } bundle_t;

  ifu_fetch_queue #(
    .ADDR_WIDTH(32), .INST_WIDTH(32), .FETCH_WIDTH(2), .QUEUE_DEPTH(DEPTH), .BOOT_ADDR(32'h0)
  ) dut (
    .clk(clk), .rst(rst),
    .bpu_taken_i(bpu_taken_i), .bpu_addr_i(bpu_addr_i),
    .bru_miss_i(bru_miss_i), .bru_addr_i(bru_addr_i),
    .exception_flush_i(exception_flush_i), .exception_addr_i(exception_addr_i),
    .stall_i(stall_i),
    .icache_req_valid_o(icache_req_valid_o), .icache_req_ready_i(icache_req_ready_i),
    .icache_addr_o(icache_addr_o),
    .icache_resp_valid_i(icache_resp_valid_i), .icache_resp_data_i(icache_resp_data_i),
    .deq_valid_o(deq_valid_o), .deq_ready_i(deq_ready_i),
    .deq_inst_o(deq_inst_o), .deq_mask_o(deq_mask_o), .deq_pc_o(deq_pc_o),
    .deq_misaligned_o(deq_misaligned_o), .ifu_flush_o(ifu_flush_o),
    .queue_count_o(queue_count_o)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] line_data(input logic [31:0] a);
    return {(a + 32'd4) ^ 32'hC0DE_5A5A, a ^ 32'hC0DE_5A5A};
  endfunction

  function automatic logic [31:0] rand_tgt();
    logic [31:0] t;
    t = 32'($urandom_range(0, 1023)) << 2;
    if ($urandom_range(0, 7) == 0) t = t | 32'($urandom_range(1, 3));
    return t;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bpu_taken_i = 0; bpu_addr_i = 0; bru_miss_i = 0; bru_addr_i = 0;
    exception_flush_i = 0; exception_addr_i = 0; stall_i = 0;
    icache_req_ready_i = 0; icache_resp_valid_i = 0; icache_resp_data_i = 0;
    deq_ready_i = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 0;
    repeat (2) next_cycle();
    rst = 1;
  endtask

  task automatic test_reset();
    idle();
    rst = 0;
    repeat (2) next_cycle();
    #1;
    checks++; if (deq_valid_o !== 1'b0) begin failures++; $display("FAIL reset_deq_valid got=%b exp=0", deq_valid_o); end
    checks++; if (queue_count_o !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", queue_count_o); end
    checks++; if (ifu_flush_o !== 1'b0) begin failures++; $display("FAIL reset_flush got=%b exp=0", ifu_flush_o); end
    checks++; if ({deq_inst_o, deq_mask_o, deq_pc_o, deq_misaligned_o} !== 99'd0) begin failures++; $display("FAIL reset_deq_data got=%h exp=0", {deq_inst_o, deq_mask_o, deq_pc_o, deq_misaligned_o}); end
    checks++; if (icache_req_valid_o !== 1'b1 || icache_addr_o !== 32'h0) begin failures++; $display("FAIL reset_req got=%b/%h exp=1/0", icache_req_valid_o, icache_addr_o); end
  endtask

  task automatic test_sequential();
    logic [31:0] a;
    do_reset();
    deq_ready_i = 1;
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      icache_req_ready_i = 1; icache_resp_valid_i = 0; #1;
      a = 32'(k * 8);
      checks++; if (icache_req_valid_o !== 1'b1 || icache_addr_o !== a) begin failures++; $display("FAIL seq_req k=%0d got=%b/%h exp=1/%h", k, icache_req_valid_o, icache_addr_o, a); end
      if (k > 0) begin
        checks++; if (deq_valid_o !== 1'b1 || deq_pc_o !== a - 32'd8 || deq_mask_o !== 2'b11 || deq_inst_o !== line_data(a - 32'd8)) begin
          failures++; $display("FAIL seq_bundle k=%0d got=%b/%h/%b exp=1/%h/11", k, deq_valid_o, deq_pc_o, deq_mask_o, a - 32'd8);
        end
      end
      next_cycle();
      icache_req_ready_i = 0; icache_resp_valid_i = 1; icache_resp_data_i = line_data(a); #1;
      checks++; if (icache_req_valid_o !== 1'b0) begin failures++; $display("FAIL seq_wait_req k=%0d got=%b exp=0", k, icache_req_valid_o); end
    end
    next_cycle();
    icache_resp_valid_i = 0; #1;
    checks++; if (deq_valid_o !== 1'b1 || deq_pc_o !== 32'h10 || deq_mask_o !== 2'b11 || deq_inst_o !== line_data(32'h10)) begin
      failures++; $display("FAIL seq_last got=%b/%h/%b exp=1/10/11", deq_valid_o, deq_pc_o, deq_mask_o);
    end
  endtask

  task automatic test_bpu();
    do_reset();
    next_cycle(); icache_req_ready_i = 1; #1;
    next_cycle(); icache_req_ready_i = 0; icache_resp_valid_i = 1; icache_resp_data_i = line_data(0);
    bpu_taken_i = 1; bpu_addr_i = 32'h104;
    next_cycle(); icache_resp_valid_i = 0; bpu_taken_i = 0; icache_req_ready_i = 1; #1;
    checks++; if (icache_req_valid_o !== 1'b1 || icache_addr_o !== 32'h100) begin failures++; $display("FAIL bpu_req got=%b/%h exp=1/100", icache_req_valid_o, icache_addr_o); end
    checks++; if (deq_pc_o !== 32'h0 || deq_mask_o !== 2'b11) begin failures++; $display("FAIL bpu_first got=%h/%b exp=0/11", deq_pc_o, deq_mask_o); end
    next_cycle(); icache_req_ready_i = 0; icache_resp_valid_i = 1; icache_resp_data_i = line_data(32'h100);
    next_cycle(); icache_resp_valid_i = 0; deq_ready_i = 1; #1;
    checks++; if (queue_count_o !== 3'd2) begin failures++; $display("FAIL bpu_count got=%0d exp=2", queue_count_o); end
    next_cycle(); deq_ready_i = 0; #1;
    checks++; if (deq_pc_o !== 32'h104 || deq_mask_o !== 2'b10 || deq_inst_o !== line_data(32'h100)) begin
      failures++; $display("FAIL bpu_bundle got=%h/%b exp=104/10", deq_pc_o, deq_mask_o);
    end
    checks++; if (icache_addr_o !== 32'h108) begin failures++; $display("FAIL bpu_seq_addr got=%h exp=108", icache_addr_o); end
  endtask

  task automatic test_full();
    do_reset();
    for (int k = 0; k < DEPTH; k++) begin
      next_cycle(); icache_req_ready_i = 1; icache_resp_valid_i = 0;
      next_cycle(); icache_req_ready_i = 0; icache_resp_valid_i = 1; icache_resp_data_i = line_data(32'(k * 8));
    end
    next_cycle(); icache_resp_valid_i = 0; icache_req_ready_i = 1; #1;
    checks++; if (queue_count_o !== 3'd4 || icache_req_valid_o !== 1'b0) begin failures++; $display("FAIL full_state got=%0d/%b exp=4/0", queue_count_o, icache_req_valid_o); end
    next_cycle(); deq_ready_i = 1; #1;
    checks++; if (icache_req_valid_o !== 1'b0) begin failures++; $display("FAIL full_hold got=%b exp=0", icache_req_valid_o); end
    next_cycle(); deq_ready_i = 0; #1;
    checks++; if (icache_req_valid_o !== 1'b1 || icache_addr_o !== 32'h20) begin failures++; $display("FAIL full_one_req got=%b/%h exp=1/20", icache_req_valid_o, icache_addr_o); end
    next_cycle(); icache_resp_valid_i = 1; icache_resp_data_i = line_data(32'h20); #1;
    checks++; if (icache_req_valid_o !== 1'b0) begin failures++; $display("FAIL full_wait got=%b exp=0", icache_req_valid_o); end
    next_cycle(); icache_resp_valid_i = 0; #1;
    checks++; if (queue_count_o !== 3'd4 || icache_req_valid_o !== 1'b0) begin failures++; $display("FAIL full_refill got=%0d/%b exp=4/0", queue_count_o, icache_req_valid_o); end
  endtask

  task automatic test_bru_flush();
    do_reset();
    next_cycle(); icache_req_ready_i = 1;
    next_cycle(); icache_req_ready_i = 0; icache_resp_valid_i = 1; icache_resp_data_i = line_data(0);
    next_cycle(); icache_req_ready_i = 1; icache_resp_valid_i = 0;
    next_cycle(); icache_req_ready_i = 0; bru_miss_i = 1; bru_addr_i = 32'h200; #1;
    checks++; if (ifu_flush_o !== 1'b1) begin failures++; $display("FAIL bru_flush got=%b exp=1", ifu_flush_o); end
    next_cycle(); bru_miss_i = 0; icache_resp_valid_i = 1; icache_resp_data_i = line_data(8); #1;
    checks++; if (ifu_flush_o !== 1'b0 || queue_count_o !== 3'd0 || deq_valid_o !== 1'b0 || icache_req_valid_o !== 1'b0) begin
      failures++; $display("FAIL bru_drop got=%b/%0d/%b/%b exp=0/0/0/0", ifu_flush_o, queue_count_o, deq_valid_o, icache_req_valid_o);
    end
    next_cycle(); icache_resp_valid_i = 0; icache_req_ready_i = 1; #1;
    checks++; if (queue_count_o !== 3'd0 || icache_req_valid_o !== 1'b1 || icache_addr_o !== 32'h200) begin
      failures++; $display("FAIL bru_resume got=%0d/%b/%h exp=0/1/200", queue_count_o, icache_req_valid_o, icache_addr_o);
    end
    next_cycle(); icache_req_ready_i = 0; icache_resp_valid_i = 1; icache_resp_data_i = line_data(32'h200);
    next_cycle(); icache_resp_valid_i = 0; #1;
    checks++; if (deq_valid_o !== 1'b1 || deq_pc_o !== 32'h200 || deq_mask_o !== 2'b11) begin failures++; $display("FAIL bru_bundle got=%b/%h/%b exp=1/200/11", deq_valid_o, deq_pc_o, deq_mask_o); end
  endtask

  task automatic test_misaligned();
    do_reset();
    next_cycle(); bru_miss_i = 1; bru_addr_i = 32'h202; #1;
    checks++; if (ifu_flush_o !== 1'b1) begin failures++; $display("FAIL mis_flush got=%b exp=1", ifu_flush_o); end
    next_cycle(); bru_miss_i = 0; icache_req_ready_i = 1; #1;
    checks++; if (icache_req_valid_o !== 1'b0) begin failures++; $display("FAIL mis_noreq got=%b exp=0", icache_req_valid_o); end
    next_cycle(); #1;
    checks++; if (deq_valid_o !== 1'b1 || deq_misaligned_o !== 1'b1 || deq_pc_o !== 32'h202 || deq_mask_o !== 2'b00 || queue_count_o !== 3'd1) begin
      failures++; $display("FAIL mis_marker got=%b/%b/%h/%b/%0d exp=1/1/202/00/1", deq_valid_o, deq_misaligned_o, deq_pc_o, deq_mask_o, queue_count_o);
    end
    next_cycle(); #1;
    checks++; if (icache_req_valid_o !== 1'b0 || queue_count_o !== 3'd1) begin failures++; $display("FAIL mis_halt got=%b/%0d exp=0/1", icache_req_valid_o, queue_count_o); end
    exception_flush_i = 1; exception_addr_i = 32'h80; bru_miss_i = 1; bru_addr_i = 32'h300;
    next_cycle(); exception_flush_i = 0; bru_miss_i = 0; #1;
    checks++; if (queue_count_o !== 3'd0 || icache_req_valid_o !== 1'b1 || icache_addr_o !== 32'h80) begin
      failures++; $display("FAIL exc_priority got=%0d/%b/%h exp=0/1/80", queue_count_o, icache_req_valid_o, icache_addr_o);
    end
    next_cycle(); icache_req_ready_i = 0; icache_resp_valid_i = 1; icache_resp_data_i = line_data(32'h80);
    next_cycle(); icache_resp_valid_i = 0; #1;
    checks++; if (deq_pc_o !== 32'h80 || deq_misaligned_o !== 1'b0) begin failures++; $display("FAIL exc_bundle got=%h/%b exp=80/0", deq_pc_o, deq_misaligned_o); end
  endtask

  task automatic test_async_reset();
    do_reset();
    next_cycle(); icache_req_ready_i = 1;
    next_cycle(); icache_req_ready_i = 0; icache_resp_valid_i = 1; icache_resp_data_i = line_data(0);
    next_cycle(); icache_req_ready_i = 1; icache_resp_valid_i = 0;
    next_cycle(); icache_req_ready_i = 0; #1;
    checks++; if (queue_count_o !== 3'd1) begin failures++; $display("FAIL areset_pre got=%0d exp=1", queue_count_o); end
    #1 rst = 0;
    #1;
    checks++; if (queue_count_o !== 3'd0 || deq_valid_o !== 1'b0 || deq_pc_o !== 32'h0 || deq_inst_o !== 64'h0) begin
      failures++; $display("FAIL areset_out got=%0d/%b/%h exp=0/0/0", queue_count_o, deq_valid_o, deq_pc_o);
    end
    checks++; if (icache_req_valid_o !== 1'b1 || icache_addr_o !== 32'h0) begin failures++; $display("FAIL areset_req got=%b/%h exp=1/0", icache_req_valid_o, icache_addr_o); end
    next_cycle(); rst = 1;
    next_cycle(); icache_req_ready_i = 1; #1;
    checks++; if (icache_req_valid_o !== 1'b1 || icache_addr_o !== 32'h0) begin failures++; $display("FAIL areset_restart got=%b/%h exp=1/0", icache_req_valid_o, icache_addr_o); end
  endtask

  task automatic test_random();
    bundle_t     m_q[$];
    bundle_t     b;
    logic [31:0] m_pc, tgt, al, c_addr;
    bit          m_out, m_drop, m_halt, m_mark, c_pend;
    bit          exp_rv, fire, rsp, fl, mark_now;
    int          c_lat, sz, off;
    do_reset();
    m_pc = 0; m_out = 0; m_drop = 0; m_halt = 0; m_mark = 0; c_pend = 0; c_lat = 0; c_addr = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      next_cycle();
      stall_i            = ($urandom_range(0, 7) == 0);
      icache_req_ready_i = ($urandom_range(0, 3) != 0);
      deq_ready_i        = ($urandom_range(0, 2) != 0);
      bru_miss_i         = ($urandom_range(0, 24) == 0);
      exception_flush_i  = ($urandom_range(0, 49) == 0);
      bru_addr_i         = rand_tgt();
      exception_addr_i   = rand_tgt();
      bpu_taken_i        = ($urandom_range(0, 3) == 0);
      bpu_addr_i         = rand_tgt();
      rsp                = c_pend && (c_lat == 0);
      icache_resp_valid_i = rsp;
      icache_resp_data_i  = rsp ? line_data(c_addr) : {$urandom(), $urandom()};
      #1;
      al     = m_pc & ~32'h7;
      exp_rv = !m_out && !m_halt && !stall_i && (m_q.size() < DEPTH);
      fl     = bru_miss_i || exception_flush_i;
      checks++; if (icache_req_valid_o !== exp_rv) begin failures++; $display("FAIL rnd_req_valid cyc=%0d got=%b exp=%b", cyc, icache_req_valid_o, exp_rv); end
      if (exp_rv) begin
        checks++; if (icache_addr_o !== al) begin failures++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc, icache_addr_o, al); end
      end
      checks++; if (ifu_flush_o !== fl) begin failures++; $display("FAIL rnd_flush cyc=%0d got=%b exp=%b", cyc, ifu_flush_o, fl); end
      checks++; if (queue_count_o !== 3'(m_q.size()) || deq_valid_o !== (m_q.size() != 0)) begin
        failures++; $display("FAIL rnd_count cyc=%0d got=%0d/%b exp=%0d", cyc, queue_count_o, deq_valid_o, m_q.size());
      end
      if (m_q.size() != 0) begin
        b = m_q[0];
        checks++; if (deq_inst_o !== b.inst || deq_mask_o !== b.mask || deq_pc_o !== b.pc || deq_misaligned_o !== b.mis) begin
          failures++; $display("FAIL rnd_head cyc=%0d got=%h/%b/%h/%b exp=%h/%b/%h/%b", cyc, deq_inst_o, deq_mask_o, deq_pc_o, deq_misaligned_o, b.inst, b.mask, b.pc, b.mis);
        end
      end
      // advance the reference model across the clock edge
      fire     = exp_rv && icache_req_ready_i;
      sz       = m_q.size();
      mark_now = m_halt && m_mark && (sz < DEPTH);
      if (fl) begin
        tgt = exception_flush_i ? exception_addr_i : bru_addr_i;
        m_q.delete();
        m_pc   = tgt;
        m_out  = (m_out && !rsp) || fire;
        m_drop = m_out;
        m_halt = (tgt % 4) != 0;
        m_mark = m_halt;
      end else begin
        if (sz != 0 && deq_ready_i) void'(m_q.pop_front());
        if (mark_now) begin
          b = '{inst: 64'h0, mask: 2'b00, pc: m_pc, mis: 1'b1};
          m_q.push_back(b);
          m_mark = 0;
        end
        if (rsp) begin
          m_out = 0;
          if (!m_drop && !m_halt) begin
            off = int'((m_pc % 8) / 4);
            b = '{inst: line_data(al), mask: {1'b1, (off == 0)}, pc: m_pc, mis: 1'b0};
            m_q.push_back(b);
            m_pc = bpu_taken_i ? bpu_addr_i : al + 32'd8;
            if (bpu_taken_i && (bpu_addr_i % 4) != 0) begin m_halt = 1; m_mark = 1; end
          end
          m_drop = 0;
        end
        if (fire) m_out = 1;
      end
      if (fire) begin
        c_pend = 1; c_addr = al; c_lat = $urandom_range(0, 3);
      end else if (rsp) begin
        c_pend = 0;
      end else if (c_pend) begin
        c_lat--;
      end
    end
    idle();
  endtask

  initial begin
    rst = 0;
    idle();
    test_reset();
    test_sequential();
    test_bpu();
    test_full();
    test_bru_flush();
    test_misaligned();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
